// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers execute results, runs the data-cache req/ack
// handshake, aligns loads, builds store strobes. Optional MISALIGN_TRAP_EN traps misaligned ops.
module mem_access_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CACHE_READY,
    input  logic              FLUSH,
    input  logic [XLEN-1:0]   DATA_ADDRESS,
    input  logic [1:0]        DATA_CACHE_CONTROL,
    input  logic [2:0]        FUN3,
    input  logic [XLEN-1:0]   STORE_DATA,
    input  logic [XLEN-1:0]   WB_DATA_IN,
    input  logic [1:0]        TYPE_IN,
    input  logic [RD_W-1:0]   RD_IN,
    output logic              DC_REQ,
    output logic              DC_WE,
    output logic [XLEN-1:0]   DC_ADDR,
    output logic [XLEN/8-1:0] DC_WSTRB,
    output logic [XLEN-1:0]   DC_WDATA,
    input  logic              DC_ACK,
    input  logic [XLEN-1:0]   DC_RDATA,
`ifdef MISALIGN_TRAP_EN
    output logic              MISALIGN,
    output logic [XLEN-1:0]   MISALIGN_ADDR,
`endif
    output logic              WB_VALID,
    output logic [RD_W-1:0]   WB_RD,
    output logic [XLEN-1:0]   WB_DATA,
    output logic              MEM_STALL
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic              cap, is_load, is_store, is_mem, sz_byte, sz_half, mis;
    logic [1:0]        ctrl, typ;
    logic [3:0]        st_strb;
    logic [XLEN-1:0]   st_wdata, ld_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [1:0]        r_lo;
    logic [2:0]        r_fun3;
    logic              r_load;

    // A flushed op degrades to a bubble: no cache access and no writeback.
    always_comb begin
        ctrl     = FLUSH ? 2'b00 : DATA_CACHE_CONTROL;
        typ      = FLUSH ? 2'b00 : TYPE_IN;
        is_store = (ctrl == 2'b01);
        is_load  = (ctrl == 2'b10);
        is_mem   = is_store | is_load;
        cap      = CACHE_READY & ~MEM_STALL;
        sz_byte  = (FUN3 == 3'b000) | (is_load & (FUN3 == 3'b100));
        sz_half  = (FUN3 == 3'b001) | (is_load & (FUN3 == 3'b101));
    end

`ifdef MISALIGN_TRAP_EN
    assign mis = is_mem & ((sz_half & DATA_ADDRESS[0]) |
                           (~sz_byte & ~sz_half & (DATA_ADDRESS[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        st_strb  = 4'b1111;
        st_wdata = STORE_DATA;
        if (sz_byte) begin
            st_strb  = 4'b0001 << DATA_ADDRESS[1:0];
            st_wdata = {4{STORE_DATA[7:0]}};
        end else if (sz_half) begin
            st_strb  = 4'b0011 << {DATA_ADDRESS[1], 1'b0};
            st_wdata = {2{STORE_DATA[15:0]}};
        end
    end

    always_comb begin
        ld_byte = DC_RDATA[{r_lo, 3'b000} +: 8];
        ld_half = DC_RDATA[{r_lo[1], 4'b0000} +: 16];
        case (r_fun3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = DC_RDATA;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            DC_REQ    <= 1'b0;
            DC_WE     <= 1'b0;
            DC_ADDR   <= '0;
            DC_WSTRB  <= '0;
            DC_WDATA  <= '0;
            WB_VALID  <= 1'b0;
            WB_RD     <= '0;
            WB_DATA   <= '0;
            MEM_STALL <= 1'b0;
            r_lo      <= '0;
            r_fun3    <= '0;
            r_load    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            MISALIGN      <= 1'b0;
            MISALIGN_ADDR <= '0;
`endif
        end else begin
`ifdef MISALIGN_TRAP_EN
            MISALIGN      <= 1'b0;
            MISALIGN_ADDR <= '0;
`endif
            case (state)
                // BUSY ignores CACHE_READY/FLUSH: the op in flight always completes.
                BUSY: if (DC_ACK) begin
                    state     <= DONE;
                    DC_REQ    <= 1'b0;
                    MEM_STALL <= 1'b0;
                    WB_VALID  <= r_load & (WB_RD != '0);
                    WB_DATA   <= ld_data;
                end
                default: begin
                    state    <= IDLE;
                    DC_REQ   <= 1'b0;
                    WB_VALID <= 1'b0;
                    if (cap) begin
                        WB_RD  <= RD_IN;
                        r_lo   <= DATA_ADDRESS[1:0];
                        r_fun3 <= FUN3;
                        r_load <= is_load;
                        if (mis) begin
`ifdef MISALIGN_TRAP_EN
                            MISALIGN      <= 1'b1;
                            MISALIGN_ADDR <= DATA_ADDRESS;
`endif
                        end else if (is_mem) begin
                            state     <= BUSY;
                            MEM_STALL <= 1'b1;
                            DC_REQ    <= 1'b1;
                            DC_WE     <= is_store;
                            DC_ADDR   <= {DATA_ADDRESS[XLEN-1:2], 2'b00};
                            DC_WSTRB  <= is_store ? st_strb : 4'b0000;
                            DC_WDATA  <= is_store ? st_wdata : '0;
                        end else begin
                            WB_VALID <= (typ != 2'b00) & (RD_IN != '0);
                            WB_DATA  <= WB_DATA_IN;
                        end
                    end
                end
            endcase
        end
    end

endmodule
